// File: rtl/hash_host_pkg.sv
// Shared types and constants for the hash job host: state encoding, bus widths
// and default job geometry.
package hash_host_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned ADDR_W = 16;

  localparam int unsigned DEF_DEPTH          = 64;
  localparam int unsigned DEF_MSG_WORDS      = 20;
  localparam int unsigned DEF_OUT_WORDS      = 16;
  localparam int unsigned DEF_MSG_BASE       = 0;
  localparam int unsigned DEF_OUT_BASE       = 32;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 4096;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_RUN,
    ST_DRAIN
  } state_e;

endpackage

// File: rtl/hash_host_ram.sv
// DEPTH x 32 single-port synchronous RAM; read-before-write, registered read
// that holds its value while en is low and can be forced to return zero.
module hash_host_ram
  import hash_host_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              we,
  input  logic              rd_zero,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] rdata_q, rdata_d;

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (en) rdata_d = rd_zero ? '0 : mem[addr];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rdata_q <= '0;
    else          rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/hash_job_host.sv
// Host side of the bitcoin hash core: loads a message, starts the core, serves
// its memory bus and drains the results. Optional watchdog: HASH_HOST_TIMEOUT_EN.
module hash_job_host
  import hash_host_pkg::*;
#(
  parameter int unsigned DEPTH          = DEF_DEPTH,
  parameter int unsigned MSG_WORDS      = DEF_MSG_WORDS,
  parameter int unsigned OUT_WORDS      = DEF_OUT_WORDS,
  parameter int unsigned MSG_BASE       = DEF_MSG_BASE,
  parameter int unsigned OUT_BASE       = DEF_OUT_BASE,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [WORD_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              err,
  output logic              core_start,
  output logic [ADDR_W-1:0] core_message_addr,
  output logic [ADDR_W-1:0] core_output_addr,
  input  logic              core_done,
  input  logic [ADDR_W-1:0] core_mem_addr,
  input  logic              core_mem_we,
  input  logic [WORD_W-1:0] core_mem_write_data,
  output logic [WORD_W-1:0] core_mem_read_data
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = ADDR_W;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  ld_cnt_q, ld_cnt_d, rd_cnt_q, rd_cnt_d, out_cnt_q, out_cnt_d;
  logic              pend_q, pend_d, out_valid_q, out_valid_d;
  logic [WORD_W-1:0] out_data_q, out_data_d, hold_q, hold_d;
  logic              in_ready_q, in_ready_d, busy_q, busy_d;
  logic              core_start_q, core_start_d, err_q, err_d;
  logic              run_rd_q, run_rd_d;

  logic              ram_en, ram_we, ram_zero;
  logic [AW-1:0]     ram_addr;
  logic [WORD_W-1:0] ram_wdata, ram_rdata;
  logic              in_range, consume, move, issue, timeout;

  assign in_range = core_mem_addr < ADDR_W'(DEPTH);

`ifdef HASH_HOST_TIMEOUT_EN
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMR_W-1:0] tmr_q, tmr_d;

  // Counter is zero in every other state, so it starts from zero on RUN entry.
  always_comb begin
    tmr_d = '0;
    if (state_q == ST_RUN) tmr_d = tmr_q + TMR_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) tmr_q <= '0;
    else          tmr_q <= tmr_d;
  end

  assign timeout = (state_q == ST_RUN) && (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;

  // TIMEOUT_CYCLES has no effect without the watchdog.
  if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
  end
`endif

  hash_host_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (ram_en),
    .we      (ram_we),
    .rd_zero (ram_zero),
    .addr    (ram_addr),
    .wdata   (ram_wdata),
    .rdata   (ram_rdata)
  );

  // Next state, RAM port mux and the two-slot drain pipeline (RAM read reg + out reg).
  always_comb begin
    state_d   = state_q;
    ld_cnt_d  = '0;
    rd_cnt_d  = '0;
    out_cnt_d = '0;
    err_d     = err_q;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_zero  = 1'b0;
    ram_addr  = AW'(MSG_BASE) + AW'(ld_cnt_q);
    ram_wdata = in_data;
    issue     = 1'b0;
    consume   = out_valid_q && out_ready;
    move      = pend_q && (!out_valid_q || consume);

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          ram_we   = 1'b1;
          ld_cnt_d = CNT_W'(1);
          err_d    = 1'b0;
          state_d  = (MSG_WORDS == 1) ? ST_START : ST_LOAD;
        end
      end
      ST_LOAD: begin
        ld_cnt_d = ld_cnt_q;
        if (in_valid) begin
          ram_we   = 1'b1;
          ld_cnt_d = ld_cnt_q + CNT_W'(1);
          if (ld_cnt_q == CNT_W'(MSG_WORDS - 1)) state_d = ST_START;
        end
      end
      ST_START: state_d = ST_RUN;
      ST_RUN: begin
        ram_en    = 1'b1;
        ram_we    = core_mem_we && in_range;
        ram_zero  = !in_range;
        ram_addr  = core_mem_addr[AW-1:0];
        ram_wdata = core_mem_write_data;
        if (core_done) begin
          state_d = ST_DRAIN;
        end else if (timeout) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end
      end
      ST_DRAIN: begin
        issue     = (rd_cnt_q < CNT_W'(OUT_WORDS)) && (!pend_q || move);
        ram_en    = issue;
        ram_addr  = AW'(OUT_BASE) + AW'(rd_cnt_q);
        rd_cnt_d  = rd_cnt_q + CNT_W'(issue);
        out_cnt_d = out_cnt_q + CNT_W'(consume);
        if (consume && (out_cnt_q == CNT_W'(OUT_WORDS - 1))) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    pend_d       = issue ? 1'b1 : (move ? 1'b0 : pend_q);
    out_valid_d  = move ? 1'b1 : (consume ? 1'b0 : out_valid_q);
    out_data_d   = move ? ram_rdata : out_data_q;
    in_ready_d   = (state_d == ST_IDLE) || (state_d == ST_LOAD);
    busy_d       = state_d != ST_IDLE;
    core_start_d = state_d == ST_START;
    run_rd_d     = state_q == ST_RUN;
    hold_d       = run_rd_q ? ram_rdata : hold_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      ld_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      out_cnt_q    <= '0;
      pend_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      hold_q       <= '0;
      in_ready_q   <= 1'b1;
      busy_q       <= 1'b0;
      core_start_q <= 1'b0;
      err_q        <= 1'b0;
      run_rd_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      ld_cnt_q     <= ld_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      out_cnt_q    <= out_cnt_d;
      pend_q       <= pend_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      hold_q       <= hold_d;
      in_ready_q   <= in_ready_d;
      busy_q       <= busy_d;
      core_start_q <= core_start_d;
      err_q        <= err_d;
      run_rd_q     <= run_rd_d;
    end
  end

  // Core sees fresh RAM data only for reads it issued; otherwise the last one is held.
  assign core_mem_read_data = run_rd_q ? ram_rdata : hold_q;
  assign core_message_addr  = ADDR_W'(MSG_BASE);
  assign core_output_addr   = ADDR_W'(OUT_BASE);
  assign in_ready           = in_ready_q;
  assign out_valid          = out_valid_q;
  assign out_data           = out_data_q;
  assign busy               = busy_q;
  assign err                = err_q;
  assign core_start         = core_start_q;

endmodule
